// File: rtl/operation_s_iter.sv
// operation_s_iter: iterated successor S^k(x), one step per clock under a start/ready handshake,
// with wrap or saturate overflow mode and a sticky overflow flag.
module operation_s_iter #(
    parameter int WIDTH    = 16,
    parameter int CWIDTH   = 8,
    parameter bit SATURATE = 1'b0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ST,
    input  logic [WIDTH-1:0]  IN,
    input  logic [CWIDTH-1:0] CNT,
    output logic              RD,
    output logic              BUSY,
    output logic [WIDTH-1:0]  RES,
    output logic              OVF
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [WIDTH-1:0]  acc_q, acc_d, res_q, res_d, acc_nx;
    logic [CWIDTH-1:0] rem_q, rem_d;
    logic              ovf_q, ovf_d, res_ovf_q, res_ovf_d, at_max;

    assign at_max = acc_q == {WIDTH{1'b1}};
    assign acc_nx = at_max ? (SATURATE ? acc_q : '0) : acc_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        ovf_d     = ovf_q;
        res_d     = res_q;
        res_ovf_d = res_ovf_q;
        if (state_q == IDLE && ST) begin
            acc_d   = IN;
            rem_d   = CNT;
            ovf_d   = 1'b0;
            state_d = CNT == '0 ? DONE : RUN;
            if (CNT == '0) begin
                res_d     = IN;
                res_ovf_d = 1'b0;
            end
        end else if (state_q == RUN) begin
            acc_d = acc_nx;
            rem_d = rem_q - 1'b1;
            ovf_d = ovf_q | at_max;
            if (rem_q == CWIDTH'(1)) begin
                state_d   = DONE;
                res_d     = acc_nx;
                res_ovf_d = ovf_q | at_max;
            end
        end else if (state_q == DONE && !ST) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            rem_q     <= '0;
            ovf_q     <= 1'b0;
            res_q     <= '0;
            res_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            ovf_q     <= ovf_d;
            res_q     <= res_d;
            res_ovf_q <= res_ovf_d;
        end
    end

    assign RD   = state_q == DONE;
    assign BUSY = state_q == RUN;
    assign RES  = res_q;
    assign OVF  = res_ovf_q;
endmodule
